// File: rtl/req_gnt_pkg.sv
// Shared lane indices, lane1 FSM state type and latency clamp helper for the
// req/gnt scheduler.
package req_gnt_pkg;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;
    localparam int LANE2 = 2;

    typedef enum logic [1:0] {
        L1_IDLE,
        L1_WAIT,
        L1_DUE
    } l1_state_t;

    function automatic int clamp_lat(input int val, input int lo, input int hi);
        if (val < lo) begin
            return lo;
        end
        if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/req_gnt_delay_lane.sv
// Lane1 delay FSM: counts cycles since accept, becomes due at the clamped
// target and slides inside the latency window until granted or dropped.
module req_gnt_delay_lane
    import req_gnt_pkg::*;
#(
    parameter int LAT1_MIN = 3,
    parameter int LAT1_MAX = 5,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [CNT_W-1:0] cfg,
    input  logic             won,
    output logic             due,
    output logic             busy,
    output logic             drop
);

    localparam logic [CNT_W-1:0] MAX_EL = CNT_W'(LAT1_MAX);

    l1_state_t        state_q, state_d;
    logic [CNT_W-1:0] el_q, el_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= L1_IDLE;
            el_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            el_q    <= el_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        el_d    = el_q;
        tgt_d   = tgt_q;
        due     = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            L1_IDLE: begin
                if (accept) begin
                    state_d = L1_WAIT;
                    el_d    = CNT_W'(1);
                    tgt_d   = CNT_W'(clamp_lat(int'(cfg), LAT1_MIN, LAT1_MAX));
                end
            end
            L1_WAIT: begin
                el_d = el_q + 1'b1;
                if ((el_q + 1'b1) == tgt_q) begin
                    state_d = L1_DUE;
                end
            end
            L1_DUE: begin
                due = 1'b1;
                if (won) begin
                    state_d = L1_IDLE;
                end else if (el_q < MAX_EL) begin
                    // A lost grant may still land later inside the window.
                    el_d = el_q + 1'b1;
                end else begin
                    drop    = 1'b1;
                    state_d = L1_IDLE;
                end
            end
            default: begin
                state_d = L1_IDLE;
            end
        endcase
    end

    assign busy = (state_q != L1_IDLE);

endmodule

// File: rtl/req_gnt_scheduler.sv
// Three-lane grant generator with fixed priority lane2 > lane0 > lane1 and a
// saturating miss counter. Define REQ_GNT_SVA_EN to compile embedded checkers.
module req_gnt_scheduler
    import req_gnt_pkg::*;
#(
    parameter int LAT1_MIN = 3,
    parameter int LAT1_MAX = 5,
    parameter int CNT_W    = 3,
    parameter int MISS_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [CNT_W-1:0]  cfg_lat1,
    output logic [2:0]        gnt,
    output logic              busy1,
    output logic [MISS_W-1:0] miss_cnt
);

    logic              req0_q, req0_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              c0, c1, c2;
    logic              lane0_drop, l1_drop;
    logic [1:0]        miss_inc;
    logic [MISS_W:0]   miss_sum;

    // Lane2 is combinational, so it must be masked while reset is held.
    assign c2 = req[LANE2] & reset;
    assign c0 = req0_q;

    req_gnt_delay_lane #(
        .LAT1_MIN (LAT1_MIN),
        .LAT1_MAX (LAT1_MAX),
        .CNT_W    (CNT_W)
    ) u_lane1 (
        .clk    (clk),
        .reset  (reset),
        .accept (req[LANE1]),
        .cfg    (cfg_lat1),
        .won    (gnt[LANE1]),
        .due    (c1),
        .busy   (busy1),
        .drop   (l1_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req0_q <= 1'b0;
            miss_q <= '0;
        end else begin
            req0_q <= req0_d;
            miss_q <= miss_d;
        end
    end

    always_comb begin
        gnt = 3'b000;
        if (c2) begin
            gnt[LANE2] = 1'b1;
        end else if (c0) begin
            gnt[LANE0] = 1'b1;
        end else if (c1) begin
            gnt[LANE1] = 1'b1;
        end
    end

    always_comb begin
        req0_d     = req[LANE0];
        lane0_drop = c0 & c2;
        miss_inc   = {1'b0, lane0_drop} + {1'b0, l1_drop};
        miss_sum   = {1'b0, miss_q} + {{(MISS_W-1){1'b0}}, miss_inc};
        miss_d     = miss_sum[MISS_W] ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];
    end

    assign miss_cnt = miss_q;

`ifdef REQ_GNT_SVA_EN
    logic l1_accept;
    assign l1_accept = req[LANE1] & ~busy1;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(gnt));

    a_lane2_now: assert property (@(posedge clk) disable iff (!reset)
        req[LANE2] |-> gnt[LANE2]);

    a_lane0_next: assert property (@(posedge clk) disable iff (!reset)
        (req[LANE0] && !req[LANE2]) ##1 !req[LANE2] |-> gnt[LANE0]);

    a_lane1_window: assert property (@(posedge clk) disable iff (!reset)
        l1_accept |-> ##[LAT1_MIN:LAT1_MAX] (gnt[LANE1] || l1_drop));

    a_miss_monotonic: assert property (@(posedge clk) disable iff (!reset)
        miss_cnt >= $past(miss_cnt));
`else
    // Checkers are left out of this build; datapath is unchanged.
`endif

endmodule

// File: tb/tb_req_gnt_scheduler.sv
// Self-checking bench for req_gnt_scheduler: directed scenarios plus random
// traffic compared against a timestamp-based reference model.
module tb_req_gnt_scheduler;

    localparam int LAT1_MIN = 3;
    localparam int LAT1_MAX = 5;
    localparam int CNT_W    = 3;
    localparam int MISS_W   = 8;
    localparam int MISS_SAT = (1 << MISS_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req;
    logic [CNT_W-1:0]  cfg_lat1;
    logic [2:0]        gnt;
    logic              busy1;
    logic [MISS_W-1:0] miss_cnt;

    int testCount = 0;
    int failCount = 0;

    // Reference model: lane1 kept as accept timestamp and target latency.
    int cycleNum = 0;
    bit mReq0    = 1'b0;
    bit mOut     = 1'b0;
    int mAcc     = 0;
    int mTgt     = 0;
    int mMiss    = 0;

    logic [2:0]        obsGnt;
    logic              obsBusy;
    logic [MISS_W-1:0] obsMiss;

    req_gnt_scheduler #(
        .LAT1_MIN (LAT1_MIN),
        .LAT1_MAX (LAT1_MAX),
        .CNT_W    (CNT_W),
        .MISS_W   (MISS_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .cfg_lat1 (cfg_lat1),
        .gnt      (gnt),
        .busy1    (busy1),
        .miss_cnt (miss_cnt)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Single comparison point: every check is counted and reported here
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int refClamp(input int v);
        if (v < LAT1_MIN) return LAT1_MIN;
        if (v > LAT1_MAX) return LAT1_MAX;
        return v;
    endfunction

    task automatic modelReset();
        mReq0 = 1'b0;
        mOut  = 1'b0;
        mMiss = 0;
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, advance the model
    // across the upcoming edge, then step to just after that edge
    task automatic applyStimulus(input logic [2:0] r, input logic [CNT_W-1:0] cfg);
        bit         c0, c1, c2;
        int         age;
        int         drops;
        logic [2:0] eGnt;
        req      = r;
        cfg_lat1 = cfg;
        #2;
        c2   = r[2];
        c0   = mReq0;
        age  = cycleNum - mAcc;
        c1   = mOut && (age >= mTgt);
        eGnt = c2 ? 3'b100 : (c0 ? 3'b001 : (c1 ? 3'b010 : 3'b000));
        obsGnt  = gnt;
        obsBusy = busy1;
        obsMiss = miss_cnt;
        checkOutput("gnt", 32'(gnt), 32'(eGnt));
        checkOutput("busy1", 32'(busy1), 32'(mOut));
        checkOutput("miss_cnt", 32'(miss_cnt), 32'(mMiss));
        drops = (c0 && c2) ? 1 : 0;
        if (c1 && (eGnt == 3'b010)) begin
            mOut = 1'b0;
        end else if (c1 && (age == LAT1_MAX)) begin
            mOut = 1'b0;
            drops++;
        end else if (!mOut && r[1]) begin
            mOut = 1'b1;
            mAcc = cycleNum;
            mTgt = refClamp(int'(cfg));
        end
        mMiss = (mMiss + drops > MISS_SAT) ? MISS_SAT : mMiss + drops;
        mReq0 = r[0];
        cycleNum++;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and release it just after the next edge
    task automatic doReset();
        reset = 1'b0;
        req   = 3'b000;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy1", 32'(busy1), 32'd0);
        checkOutput("rst_miss", 32'(miss_cnt), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Pulse req[1] and measure the cycle of the first gnt[1]
    task automatic lat1Probe(input logic [CNT_W-1:0] cfg, input int expLat);
        int found;
        found = -1;
        applyStimulus(3'b010, cfg);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(3'b000, CNT_W'($urandom_range(0, 7)));
            if (k == 1) checkOutput("busy1_set", 32'(obsBusy), 32'd1);
            if (k == expLat + 1) checkOutput("busy1_clear", 32'(obsBusy), 32'd0);
            if (obsGnt[1] && (found < 0)) found = k;
        end
        checkOutput($sformatf("lat1_cfg%0d", cfg), 32'(found), 32'(expLat));
    endtask

    // Reset arriving while lane1 is waiting discards it without a miss
    task automatic resetMidWait();
        int seen;
        applyStimulus(3'b010, 3'd4);
        applyStimulus(3'b000, 3'd4);
        checkOutput("busy_before_rst", 32'(obsBusy), 32'd1);
        req = 3'b100;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("mid_rst_busy1", 32'(busy1), 32'd0);
        checkOutput("mid_rst_miss", 32'(miss_cnt), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(3'b000, 3'd4);
            if (obsGnt[1]) seen++;
        end
        checkOutput("no_l1_after_rst", 32'(seen), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int seen1;
        logic [2:0] r;
        reset    = 1'b0;
        req      = 3'b000;
        cfg_lat1 = '0;
        #1;
        checkOutput("init_gnt", 32'(gnt), 32'd0);
        checkOutput("init_busy1", 32'(busy1), 32'd0);
        checkOutput("init_miss", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Lane0 single pulse
        applyStimulus(3'b001, 3'd0);
        applyStimulus(3'b000, 3'd0);
        checkOutput("lane0_gnt", 32'(obsGnt), 32'b001);
        applyStimulus(3'b000, 3'd0);
        checkOutput("lane0_once", 32'(obsGnt), 32'd0);
        checkOutput("lane0_miss", 32'(obsMiss), 32'd0);

        // Lane1 latency, nominal and clamped
        lat1Probe(3'd4, 4);
        lat1Probe(3'd1, 3);
        lat1Probe(3'd7, 5);
        lat1Probe(3'd0, 3);

        // Lane1 starved by lane2 slides to the window end and drops
        doReset();
        applyStimulus(3'b110, 3'd4);
        seen1 = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(3'b100, 3'd4);
            checkOutput("slide_gnt", 32'(obsGnt), 32'b100);
            if (obsGnt[1]) seen1++;
        end
        applyStimulus(3'b000, 3'd4);
        checkOutput("slide_no_gnt1", 32'(seen1), 32'd0);
        checkOutput("slide_miss", 32'(obsMiss), 32'd1);
        checkOutput("slide_busy1", 32'(obsBusy), 32'd0);

        // Lane0 collisions with lane2, then saturation
        doReset();
        applyStimulus(3'b001, 3'd4);
        applyStimulus(3'b100, 3'd4);
        checkOutput("collide_gnt", 32'(obsGnt), 32'b100);
        applyStimulus(3'b000, 3'd4);
        checkOutput("collide_miss", 32'(obsMiss), 32'd1);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(3'b101, 3'd4);
        end
        applyStimulus(3'b000, 3'd4);
        checkOutput("miss_sat", 32'(obsMiss), 32'(MISS_SAT));

        // Reset while lane1 is in flight
        doReset();
        resetMidWait();

        // Random traffic with occasional resets
        doReset();
        for (int i = 0; i < 2000; i++) begin
            r[0] = 1'($urandom_range(0, 1));
            r[1] = ($urandom_range(0, 2) == 0);
            r[2] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                doReset();
            end
            applyStimulus(r, CNT_W'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
